// File: rtl/sc_pkg.sv
// Shared types and sizing helpers for the stochastic-computing stages.
// Used by the bitstream source and the bitstream counter.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sc_state_t;

  localparam int SC_WIN_LEN = 256;

  // Bits needed to hold the value win_len itself.
  function automatic int sc_cnt_w(input int win_len);
    return $clog2(win_len + 1);
  endfunction

endpackage

// File: rtl/sc_win_counter.sv
// Window sample counter with terminal-count flag.
// Wraps to zero on the sample that completes a window.
module sc_win_counter
  import sc_pkg::*;
#(
  parameter int N = SC_WIN_LEN,
  parameter int W = sc_cnt_w(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == LAST);

  // Count accepted samples; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/sc_bitstream_counter.sv
// Stochastic bitstream decoder: counts ones over a window
// of accepted samples and hands the total off via valid/ready.
module sc_bitstream_counter
  import sc_pkg::*;
#(
  parameter int WIN_LEN = SC_WIN_LEN,
  parameter int CNT_W   = sc_cnt_w(WIN_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic             out_valid,
  input  logic             out_ready
);

  sc_state_t        state;
  logic [CNT_W-1:0] acc;
  logic             take;
  logic             hshk;
  logic             go;
  logic             tc;

  assign take = (state == RUN) && bit_vld;
  assign hshk = (state == HOLD) && out_ready;
  assign go   = start && ((state == IDLE) || hshk);

  sc_win_counter #(
    .N (WIN_LEN),
    .W (CNT_W)
  ) u_win (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .inc   (take),
    .tc    (tc)
  );

  // Window FSM, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      count_out <= '0;
      acc       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            acc   <= '0;
          end
        end
        RUN: begin
          if (bit_vld) begin
            if (tc) begin
              count_out <= acc + CNT_W'(bit_in);
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= HOLD;
              acc       <= '0;
            end else begin
              acc <= acc + CNT_W'(bit_in);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state <= RUN;
              busy  <= 1'b1;
              acc   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_bitstream_counter.sv
// Scoreboard bench for sc_bitstream_counter.
// Reference popcounts come from the accepted-sample stream.
module tb_sc_bitstream_counter;

  localparam int WIN_LEN = 256;
  localparam int CNT_W   = $clog2(WIN_LEN + 1);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             bit_in;
  logic             bit_vld;
  logic             busy;
  logic [CNT_W-1:0] count_out;
  logic             out_valid;
  logic             out_ready;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int last_exp = 0;
  logic [7:0] lfsr;

  sc_bitstream_counter #(
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .busy      (busy),
    .count_out (count_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Monitor: every handshake consumes one expected count.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_result", 1, 0);
        end else begin
          chk("sb_count", int'(count_out), exp_q.pop_front());
        end
      end
    end
  end

  // 8-bit LFSR x^8+x^6+x^5+x^4+1 feeding a "< 85" comparator.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic pulse_start();
    start   = 1'b1;
    bit_vld = 1'b1;
    bit_in  = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    bit_vld = 1'b0;
    bit_in  = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_no_valid", int'(out_valid), 0);
  endtask

  // Drive until n samples are accepted; full windows are scored.
  task automatic feed(input int mode, input int n);
    int   got;
    int   ones;
    int   cyc;
    logic v;
    logic b;
    logic last;
    got  = 0;
    ones = 0;
    cyc  = 0;
    while (got < n && cyc < 5000) begin
      v = 1'b1;
      b = 1'b0;
      case (mode)
        0: b = 1'b1;
        1: b = 1'b0;
        2: b = (got % 2) == 0;
        3: begin
          v = (cyc % 3) == 0;
          b = 1'b1;
        end
        4: begin
          v = 1'($urandom % 2);
          b = 1'($urandom % 2);
        end
        default: begin
          v = ($urandom % 4) != 0;
          if (v) begin
            b    = lfsr < 8'd85;
            lfsr = lfsr_next(lfsr);
          end else begin
            b = 1'($urandom % 2);
          end
        end
      endcase
      start   = (mode == 4) && ($urandom % 8 == 0);
      bit_vld = v;
      bit_in  = b;
      if (v) begin
        ones += int'(b);
        got++;
      end
      last = v && (got == n) && (n == WIN_LEN);
      if (last) begin
        exp_q.push_back(ones);
        last_exp = ones;
        chk("valid_before_last_edge", int'(out_valid), 0);
      end
      @(posedge clk); #1;
      cyc++;
      if (last) begin
        chk("valid_after_last", int'(out_valid), 1);
        chk("busy_after_last", int'(busy), 0);
        if (mode == 3) chk("gap_cycles", cyc, 766);
      end
    end
    if (got < n) chk("feed_timeout", got, n);
    start   = 1'b0;
    bit_vld = 1'b0;
    bit_in  = 1'b0;
  endtask

  task automatic finish_hs();
    @(posedge clk); #1;
    chk("hs_valid_low", int'(out_valid), 0);
    chk("hs_idle", int'(busy), 0);
    chk("retain_count", int'(count_out), last_exp);
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_vld   = 1'b0;
    out_ready = 1'b1;
    lfsr      = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_count", int'(count_out), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    pulse_start(); feed(0, WIN_LEN); finish_hs();
    chk("all_ones", last_exp, 256);
    pulse_start(); feed(1, WIN_LEN); finish_hs();
    pulse_start(); feed(2, WIN_LEN); finish_hs();
    chk("alternating", last_exp, 128);
    pulse_start(); feed(3, WIN_LEN); finish_hs();
    pulse_start(); feed(4, WIN_LEN); finish_hs();

    // Backpressure with an ignored start in HOLD.
    out_ready = 1'b0;
    pulse_start(); feed(4, WIN_LEN);
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      @(posedge clk); #1;
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_count", int'(count_out), last_exp);
      chk("bp_busy", int'(busy), 0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    finish_hs();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_start_not_queued", int'(busy), 0);

    // Back-to-back: handshake and start in the same cycle.
    out_ready = 1'b0;
    pulse_start(); feed(4, WIN_LEN);
    @(posedge clk); #1;
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_valid", int'(out_valid), 0);
    lfsr = 8'd1;
    feed(5, WIN_LEN); finish_hs();

    // Reset after 100 accepted samples discards the window.
    pulse_start(); feed(0, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_count", int'(count_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", int'(out_valid), 0);
    pulse_start(); feed(4, WIN_LEN); finish_hs();

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
